multi_display: RTL and testbench
================================

# multi_display

Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display. It scans one digit per refresh slot and supports per-digit decimal points, per-digit blanking, leading-zero suppression and PWM brightness. A load/ack handshake applies new content only at frame boundaries, so a frame never mixes old and new digits. It sits between the application's BCD/hex result registers and the board's anode/cathode pins, replacing the fixed 8-digit scanner.

## Interface
Parameters:
- N_DIGITS, 8: number of digits scanned; legal range 2..16.
- REFRESH_DIV, 100_000: clock cycles per digit slot; must be ≥ 2.
- DIM_BITS, 3: brightness resolution in bits; legal range 1..6.

Ports (one clock; reset is asynchronous and active-low):
- ck  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  4*N_DIGITS  digit i value on [4i+3:4i]; digit 0 is rightmost.
- dp_in  in  N_DIGITS  decimal-point request per digit, active-high.
- blank_in  in  N_DIGITS  forced blank per digit, active-high.
- lz_en  in  1  leading-zero suppression enable; sampled with load.
- load  in  1  single-cycle or level request to capture digits_in, dp_in, blank_in and lz_en.
- load_ack  out  1  one-cycle pulse when captured content becomes visible.
- brightness  in  DIM_BITS  duty select, read live; duty = (brightness+1)/2^DIM_BITS.
- an  out  N_DIGITS  anode enables, active-low, one-hot-low or all-high.
- c  out  7  {ca,cb,cc,cd,ce,cf,cg}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Slot timer: counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and sel advances.
- sel: counts 0..N_DIGITS-1 and wraps to 0. A frame boundary is the terminal count while sel == N_DIGITS-1.
- Staging: each cycle with load=1, the inputs are copied into staging and pending is set. Repeated loads before the boundary are last-wins and produce a single ack.
- Apply: at a frame boundary with pending=1, staging is copied to the display registers, pending clears and load_ack pulses. If load=1 on that same cycle, the old staging is applied, the new inputs are captured, and pending stays 1.
- Leading-zero suppression (lz_en=1): digit i (i>0) is suppressed when it equals 0, its dp bit is clear, and every higher digit is also suppressed. Any nonzero digit or set dp stops suppression for all lower digits. Digit 0 is never suppressed.
- A digit is dark when its blank bit is set or it is suppressed. A dark digit drives its an bit high, c = 7'h7F and dp = 1.
- PWM: a free-running DIM_BITS counter increments every cycle. The selected anode is driven low only while pwm_cnt ≤ brightness; otherwise all an bits are high. c and dp follow the selected digit regardless of PWM.
- Segment encoding uses the team's standard hex table: 0=0000001, 1=1001111, 8=0000000, A=0001000, F=0111000.
- Reset values:
  - an = all ones, c = 7'h7F, dp = 1, load_ack = 0, frame_start = 0.
  - sel = 0, slot timer = 0, pwm_cnt = 0, pending = 0.
  - Display and staging digits = 0, blank mask = all ones (nothing lit until the first applied load).

## Timing
- an, c, dp, load_ack and frame_start are registered: 1 cycle after the internal sel, slot or PWM state that produces them.
- frame_start is high on the cycle when an first selects digit 0 of a new frame. The first frame_start occurs REFRESH_DIV*N_DIGITS+1 cycles after reset release.
- Load latency: load_ack follows at most REFRESH_DIV*N_DIGITS+1 cycles after load. New content is first visible in the same cycle as load_ack, together with frame_start.
- A brightness change takes effect on the next cycle, mid-slot.
- Reset asserted mid-frame forces all outputs to their reset values immediately. Pending content is discarded.

## Test plan
Parameters for all scenarios: N_DIGITS=4, REFRESH_DIV=4, DIM_BITS=2, brightness=3.
- Reset release with no load -> an=4'b1111, c=7'h7F, dp=1 for 2 frames; frame_start pulses every 16 cycles.
- load digits=16'h12A0, dp=4'b0100, blank=0, lz_en=0 -> one load_ack at the next boundary. Then an cycles 1110,1101,1011,0111, each for 4 cycles, with c = 0000001, 0001000, 0010010, 1001111; dp=0 only while an=1011.
- lz_en=1, digits=16'h0050, dp=0 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. Repeat with dp=4'b0100 -> digit 2 shows 0 with dp lit; digit 3 stays dark.
- brightness=0 -> in each 4-cycle slot the selected anode is low for exactly 1 cycle. brightness=2 -> low for 3 of 4 cycles.
- Three loads in one frame (values 1111, 2222, 3333) -> a single load_ack; display shows 3333, and no 1111 or 2222 frame ever appears.
- Assert rst_n=0 during digit 2's slot with pending=1 -> outputs are at reset values on the next edge. After release there is no load_ack and the display stays blank.

Source files
------------

// File: rtl/multi_display.sv
// Time-multiplexed N-digit common-anode 7-segment driver with PWM dimming and frame-aligned content updates.
// Latency: an/c/dp/frame_start/load_ack are registered one cycle after the scan state; new content appears at the next frame start.
// Backpressure: none on load; repeated loads before a frame boundary are merged last-wins into a single load_ack.
module multi_display #(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 100_000,
    parameter int DIM_BITS    = 3
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic                    lz_en,
    input  logic                    load,
    output logic                    load_ack,
    input  logic [DIM_BITS-1:0]     brightness,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              c,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int SEL_W  = $clog2(N_DIGITS);
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_DIGITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);

    // Everything the display needs for one frame, captured as a unit.
    typedef struct packed {
        logic [4*N_DIGITS-1:0] digits;
        logic [N_DIGITS-1:0]   dp;
        logic [N_DIGITS-1:0]   blank;
        logic                  lz;
    } content_t;

    localparam content_t CONTENT_RST = '{digits: '0, dp: '0, blank: '1, lz: 1'b0};

    logic [SLOT_W-1:0]   slot_cnt;
    logic [SEL_W-1:0]    sel;
    logic [DIM_BITS-1:0] pwm_cnt;
    content_t            stg;
    content_t            disp;
    logic                pending;
    logic                apply_d;
    logic                new_frame_d;

    logic                slot_end;
    logic                boundary;
    logic [N_DIGITS-1:0] supp;
    logic                supp_run;
    logic [3:0]          cur_dig;
    logic                cur_dp;
    logic                cur_dark;

    assign slot_end = (slot_cnt == SLOT_LAST);
    assign boundary = slot_end && (sel == SEL_LAST);

    // Standard active-low hex segment table, bit order {ca..cg}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Slot timer, digit select and free-running PWM counter.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            sel      <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DIM_BITS'(1);
            if (slot_end) begin
                slot_cnt <= '0;
                sel      <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end
        end
    end

    // Staging capture and frame-boundary apply; a load on the boundary cycle stays pending for the next frame.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            stg         <= CONTENT_RST;
            disp        <= CONTENT_RST;
            pending     <= 1'b0;
            apply_d     <= 1'b0;
            new_frame_d <= 1'b0;
        end else begin
            apply_d     <= boundary && pending;
            new_frame_d <= boundary;
            if (boundary && pending) begin
                disp <= stg;
            end
            if (load) begin
                stg <= '{digits: digits_in, dp: dp_in, blank: blank_in, lz: lz_en};
            end
            pending <= load || (pending && !boundary);
        end
    end

    // Leading-zero suppression, scanning from the most significant digit down; digit 0 is never suppressed.
    always_comb begin
        supp     = '0;
        supp_run = disp.lz;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            if (supp_run && (disp.digits[4*i +: 4] == 4'h0) && !disp.dp[i]) begin
                supp[i] = 1'b1;
            end else begin
                supp_run = 1'b0;
            end
        end
    end

    // Pick out the currently scanned digit's value, decimal point and dark state.
    always_comb begin
        cur_dig  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (sel == SEL_W'(i)) begin
                cur_dig  = disp.digits[4*i +: 4];
                cur_dp   = disp.dp[i];
                cur_dark = disp.blank[i] || supp[i];
            end
        end
    end

    // Registered pin drivers; PWM gates only the anode so cathodes stay stable through the slot.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            c           <= 7'h7F;
            dp          <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            load_ack    <= apply_d;
            frame_start <= new_frame_d;
            if (cur_dark) begin
                an <= '1;
                c  <= 7'h7F;
                dp <= 1'b1;
            end else begin
                c  <= seg7(cur_dig);
                dp <= !cur_dp;
                an <= (pwm_cnt <= brightness) ? ~(N_DIGITS'(1) << sel) : '1;
            end
        end
    end

endmodule

// File: tb/tb_multi_display.sv
// Randomised and directed bench for multi_display with a frame-level reference model and scoreboard.
// Latency: expected pin values are queued at each rising edge and compared at the following falling edge.
// Backpressure: not applicable; the monitor consumes one expectation per cycle.
module tb_multi_display;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int DB    = 2;
    localparam int FRAME = N * RD;

    logic            ck = 1'b0;
    logic            rst_n = 1'b0;
    logic [4*N-1:0]  digits_in = '0;
    logic [N-1:0]    dp_in = '0;
    logic [N-1:0]    blank_in = '0;
    logic            lz_en = 1'b0;
    logic            load = 1'b0;
    logic [DB-1:0]   brightness = 2'd3;
    logic            load_ack;
    logic [N-1:0]    an;
    logic [6:0]      c;
    logic            dp;
    logic            frame_start;

    multi_display #(.N_DIGITS(N), .REFRESH_DIV(RD), .DIM_BITS(DB)) dut (
        .ck(ck), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_en(lz_en), .load(load), .load_ack(load_ack),
        .brightness(brightness), .an(an), .c(c), .dp(dp), .frame_start(frame_start)
    );

    initial forever #5 ck = ~ck;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   c;
        logic         dp;
        logic         ack;
        logic         fs;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Reference model state: what is on screen, what is waiting, and cycles since reset release.
    int             m_t = 0;
    logic [4*N-1:0] sh_dig, st_dig;
    logic [N-1:0]   sh_dp, sh_bl, st_dp, st_bl;
    logic           sh_lz, st_lz;
    bit             m_pend, m_ack_due;

    task automatic model_reset();
        m_t = 0;
        sh_dig = '0; sh_dp = '0; sh_bl = '1; sh_lz = 1'b0;
        st_dig = '0; st_dp = '0; st_bl = '1; st_lz = 1'b0;
        m_pend = 1'b0;
        m_ack_due = 1'b0;
    endtask

    // A digit above 0 is suppressed when lz is on and it and every digit above it are zero without a dp.
    function automatic logic [N-1:0] dark_mask();
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            logic sup;
            sup = 1'b0;
            if (i > 0 && sh_lz) begin
                sup = 1'b1;
                for (int j = i; j < N; j++)
                    if (sh_dig[4*j +: 4] != 4'h0 || sh_dp[j]) sup = 1'b0;
            end
            m[i] = sh_bl[i] | sup;
        end
        return m;
    endfunction

    initial model_reset();

    always @(negedge rst_n) exp_q.delete();

    // Model: predict this edge's registered outputs from the pre-edge view, then apply this edge's inputs.
    always @(posedge ck) begin
        exp_t e;
        if (!rst_n) begin
            e.an = '1; e.c = 7'h7F; e.dp = 1'b1; e.ack = 1'b0; e.fs = 1'b0;
            model_reset();
        end else begin
            int s, p;
            logic [N-1:0] dk;
            s  = (m_t / RD) % N;
            p  = m_t % (1 << DB);
            dk = dark_mask();
            e.fs  = (m_t > 0) && (m_t % FRAME == 0);
            e.ack = m_ack_due;
            m_ack_due = 1'b0;
            if (dk[s]) begin
                e.an = '1; e.c = 7'h7F; e.dp = 1'b1;
            end else begin
                e.c  = seg_tab[sh_dig[4*s +: 4]];
                e.dp = ~sh_dp[s];
                e.an = (p <= int'(brightness)) ? ~(N'(1) << s) : '1;
            end
            m_t++;
            if ((m_t % FRAME == 0) && m_pend) begin
                sh_dig = st_dig; sh_dp = st_dp; sh_bl = st_bl; sh_lz = st_lz;
                m_pend = 1'b0;
                m_ack_due = 1'b1;
            end
            if (load) begin
                st_dig = digits_in; st_dp = dp_in; st_bl = blank_in; st_lz = lz_en;
                m_pend = 1'b1;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: compare the pins against the oldest expectation once per cycle.
    always @(negedge ck) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("an", 32'(an), 32'(e.an));
            chk("c", 32'(c), 32'(e.c));
            chk("dp", 32'(dp), 32'(e.dp));
            chk("load_ack", 32'(load_ack), 32'(e.ack));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p,
                           input logic [N-1:0] b, input logic lz);
        digits_in = d; dp_in = p; blank_in = b; lz_en = lz; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Advance until the model's cycle count reaches the requested phase within a frame.
    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != ph; i++) step();
    endtask

    initial begin
        run(3);
        rst_n = 1'b1;
        // Idle after reset: dark display, periodic frame_start.
        run(2 * FRAME + 2);
        // Plain content, no suppression.
        do_load(16'h12A0, 4'b0100, 4'b0000, 1'b0);
        run(3 * FRAME);
        // Leading-zero suppression, then a dp that stops it.
        do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
        run(2 * FRAME);
        do_load(16'h0050, 4'b0100, 4'b0000, 1'b1);
        run(2 * FRAME);
        // Brightness sweep, changed mid-slot.
        brightness = 2'd0; run(FRAME);
        brightness = 2'd2; run(FRAME);
        brightness = 2'd1; run(RD / 2);
        brightness = 2'd3; run(FRAME);
        // Three loads merged into one frame update.
        wait_phase(1);
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        do_load(16'h3333, 4'b0000, 4'b0000, 1'b0);
        run(3 * FRAME);
        // Load on the boundary cycle while another load is pending.
        wait_phase(3);
        do_load(16'h4567, 4'b0001, 4'b0000, 1'b0);
        wait_phase(FRAME - 1);
        do_load(16'h89BC, 4'b1000, 4'b0010, 1'b0);
        run(3 * FRAME);
        // Reset during digit 2's slot with a pending load.
        wait_phase(1);
        do_load(16'hDEF9, 4'b1111, 4'b0000, 1'b0);
        wait_phase(2 * RD + 1);
        rst_n = 1'b0;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_c", 32'(c), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_ack", 32'(load_ack), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        run(2);
        rst_n = 1'b1;
        run(3 * FRAME);
        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            lz_en     = 1'($urandom);
            load      = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
            step();
        end
        load = 1'b0;
        run(2 * FRAME);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
